// File: rtl/tinyalu_cmd_issuer.sv
// Command front-end for the TinyALU core: buffers commands in a FIFO, runs them one at a time
// under the start/done protocol with a done watchdog, and returns status-tagged responses.
module tinyalu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic [1:0]  rsp_status,

    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  op,
    output logic        start,
    input  logic        done,
    input  logic [15:0] result
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusNoop    = 2'b01;
    localparam logic [1:0] StatusIllegal = 2'b10;
    localparam logic [1:0] StatusTimeout = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push, pop;
    logic [18:0]   head;
    logic [7:0]    head_a, head_b;
    logic [2:0]    head_op;

    assign full      = (count_q == (AW + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    // Gated by reset_n so the upstream never sees a handshake during reset.
    assign cmd_ready = reset_n && !full;
    assign push      = cmd_valid && cmd_ready;

    assign head    = mem[rd_ptr_q];
    assign head_a  = head[7:0];
    assign head_b  = head[15:8];
    assign head_op = head[18:16];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        start_q, start_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic [2:0]  rsp_op_q, rsp_op_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic        head_legal;

    assign head_legal = (head_op != 3'd0) && (head_op <= 3'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            start_q      <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            start_q      <= start_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        start_d      = start_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_status_d = rsp_status_q;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    rsp_op_d = head_op;
                    if (head_legal) begin
                        a_d     = head_a;
                        b_d     = head_b;
                        op_d    = head_op;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        // No-op and illegal opcodes complete locally; the ALU pins stay put.
                        rsp_result_d = '0;
                        rsp_status_d = (head_op == 3'd0) ? StatusNoop : StatusIllegal;
                        state_d      = StResp;
                    end
                end
            end
            StBusy: begin
                if (done) begin
                    rsp_result_d = result;
                    rsp_status_d = StatusOk;
                    start_d      = 1'b0;
                    state_d      = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_result_d = 16'hFFFF;
                    rsp_status_d = StatusTimeout;
                    start_d      = 1'b0;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign A          = a_q;
    assign B          = b_q;
    assign op         = op_q;
    assign start      = start_q;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Self-checking bench for tinyalu_cmd_issuer: ALU model with selectable done behaviour,
// response scoreboard, and start-pulse tracker.
`timescale 1ns/1ps
module tb_tinyalu_cmd_issuer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic [1:0]  rsp_status;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;

    always #5 clk = ~clk;

    tinyalu_cmd_issuer #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_op    (rsp_op),
        .rsp_status(rsp_status),
        .A         (A),
        .B         (B),
        .op        (op),
        .start     (start),
        .done      (done),
        .result    (result)
    );

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] o);
        case (o)
            3'd1:    return {8'h00, a} + {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: done is sampled by the DUT two edges after start rises.
    logic        alu_en     = 1'b1;
    logic        stray_done = 1'b0;
    logic        alu_done   = 1'b0;
    logic [7:0]  alu_cnt    = 8'd0;
    logic [15:0] alu_res    = 16'h0000;

    assign done   = alu_done | stray_done;
    assign result = alu_res;

    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (!start) begin
            alu_cnt <= 8'd0;
        end else begin
            alu_cnt <= alu_cnt + 8'd1;
            if (alu_en && alu_cnt == 8'd0) begin
                alu_done <= 1'b1;
                alu_res  <= alu_calc(A, B, op);
            end
        end
    end

    // Start-pulse tracker: rises, last high-run length, minimum low gap between pulses.
    int   start_rises = 0;
    int   hi_run      = 0;
    int   last_hi_run = 0;
    int   lo_run      = 0;
    int   min_gap     = 1000;
    logic prev_start  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (start === 1'b1) begin
            if (!prev_start) begin
                if (start_rises > 0 && lo_run < min_gap) min_gap = lo_run;
                start_rises++;
                hi_run = 0;
            end
            hi_run++;
        end else begin
            if (prev_start) begin
                last_hi_run = hi_run;
                lo_run      = 0;
            end
            lo_run++;
        end
        prev_start = (start === 1'b1);
    end

    // Scoreboard: {result, op, status} pushed at command acceptance, popped at response handshake.
    logic [20:0] sb[$];
    logic [20:0] mon_exp;

    initial forever begin
        @(negedge clk);
        if (reset_n && rsp_valid && rsp_ready) begin
            n_checks++;
            n_rsp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got result=%h op=%0d status=%b, required no response",
                         rsp_result, rsp_op, rsp_status);
            end else begin
                mon_exp = sb.pop_front();
                if ({rsp_result, rsp_op, rsp_status} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rsp_data: got result=%h op=%0d status=%b, required result=%h op=%0d status=%b",
                             rsp_result, rsp_op, rsp_status, mon_exp[20:5], mon_exp[4:2], mon_exp[1:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                        input logic [20:0] exp);
        bit accepted = 0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = o;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            sb.push_back(exp);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_accept: got cmd_ready=0 for 200 cycles, required acceptance");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_op    = 3'd0;
        rsp_ready = 1'b0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({start, A, B, op} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_alu_pins: got start=%b A=%h B=%h op=%0d, required all 0",
                     start, A, B, op);
        end
        n_checks++;
        if ({rsp_valid, rsp_result, rsp_op, rsp_status} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b result=%h op=%0d status=%b, required all 0",
                     rsp_valid, rsp_result, rsp_op, rsp_status);
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_cmd_ready: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single_add();
        int r0;
        bit ok;
        rsp_ready = 1'b1;
        r0 = start_rises;
        send(8'h12, 8'h34, 3'd1, {16'h0046, 3'd1, 2'b00});
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL add_start_e0: got %b, required 0", start);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({start, A, B, op} !== {1'b1, 8'h12, 8'h34, 3'd1}) begin
            n_fail++;
            $display("FAIL add_issue_e1: got start=%b A=%h B=%h op=%0d, required 1 12 34 1",
                     start, A, B, op);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, start} !== 2'b01) begin
            n_fail++;
            $display("FAIL add_e2: got rsp_valid=%b start=%b, required 0 1", rsp_valid, start);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, start, rsp_status} !== 4'b1000) begin
            n_fail++;
            $display("FAIL add_e3: got rsp_valid=%b start=%b status=%b, required 1 0 00",
                     rsp_valid, start, rsp_status);
        end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL add_drain: got %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (last_hi_run !== 2 || start_rises - r0 !== 1) begin
            n_fail++;
            $display("FAIL add_start_width: got width=%0d rises=%0d, required 2 1",
                     last_hi_run, start_rises - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        bit ok;
        rsp_ready = 1'b1;
        r0 = start_rises;
        min_gap = 1000;
        send(8'hFF, 8'hFF, 3'd4, {16'hFE01, 3'd4, 2'b00});
        send(8'hF0, 8'h0F, 3'd3, {16'h00FF, 3'd3, 2'b00});
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (start_rises - r0 !== 2 || min_gap < 2) begin
            n_fail++;
            $display("FAIL b2b_start_gap: got rises=%0d gap=%0d, required 2 and gap>=2",
                     start_rises - r0, min_gap);
        end
    endtask

    task automatic test_fill();
        int r0;
        bit ok;
        rsp_ready = 1'b0;
        r0 = n_rsp;
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(8'(i + 1), 8'(3 * i), 3'd1,
                 {alu_calc(8'(i + 1), 8'(3 * i), 3'd1), 3'd1, 2'b00});
        end
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got cmd_ready=%b, required 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_a     = 8'hAA;
        cmd_b     = 8'h55;
        cmd_op    = 3'd2;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_result} !== {1'b0, 1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL fill_hold: got cmd_ready=%b rsp_valid=%b result=%h, required 0 1 0001",
                     cmd_ready, rsp_valid, rsp_result);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(ok);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || n_rsp - r0 !== DEPTH + 1) begin
            n_fail++;
            $display("FAIL fill_drain: got %0d responses, required %0d", n_rsp - r0, DEPTH + 1);
        end
    endtask

    task automatic test_noop_illegal();
        int r0;
        bit ok;
        rsp_ready = 1'b1;
        r0 = start_rises;
        send(8'h03, 8'h04, 3'd1, {16'h0007, 3'd1, 2'b00});
        send(8'h09, 8'h09, 3'd0, {16'h0000, 3'd0, 2'b01});
        send(8'h05, 8'h06, 3'd1, {16'h000B, 3'd1, 2'b00});
        send(8'h01, 8'h02, 3'd6, {16'h0000, 3'd6, 2'b10});
        send(8'h80, 8'h80, 3'd1, {16'h0100, 3'd1, 2'b00});
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mix_drain: got %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (start_rises - r0 !== 3) begin
            n_fail++;
            $display("FAIL mix_start_rises: got %0d, required 3", start_rises - r0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        rsp_ready = 1'b0;
        alu_en    = 1'b0;
        send(8'h01, 8'h02, 3'd1, {16'hFFFF, 3'd1, 2'b11});
        send(8'h03, 8'h04, 3'd1, {16'h0007, 3'd1, 2'b00});
        n_checks++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL to_start: got %b, required 1", start);
        end
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, start} !== 2'b01) begin
            n_fail++;
            $display("FAIL to_early: got rsp_valid=%b start=%b, required 0 1", rsp_valid, start);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, start, rsp_status, rsp_result} !== {1'b1, 1'b0, 2'b11, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL to_expire: got rsp_valid=%b start=%b status=%b result=%h, required 1 0 11 ffff",
                     rsp_valid, start, rsp_status, rsp_result);
        end
        @(negedge clk);
        n_checks++;
        if (last_hi_run !== TIMEOUT) begin
            n_fail++;
            $display("FAIL to_start_width: got %0d, required %0d", last_hi_run, TIMEOUT);
        end
        alu_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_result} !== {1'b1, 2'b11, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL to_stray_resp: got rsp_valid=%b status=%b result=%h, required 1 11 ffff",
                     rsp_valid, rsp_status, rsp_result);
        end
        rsp_ready = 1'b1;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_drain: got %0d pending, required 0", sb.size());
        end
        stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        n_checks++;
        if ({rsp_valid, start} !== 2'b00) begin
            n_fail++;
            $display("FAIL to_stray_idle: got rsp_valid=%b start=%b, required 0 0", rsp_valid, start);
        end
        send(8'h21, 8'h10, 3'd1, {16'h0031, 3'd1, 2'b00});
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_next_add: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        bit ok;
        rsp_ready = 1'b1;
        alu_en    = 1'b0;
        send(8'h01, 8'h01, 3'd1, {16'h0002, 3'd1, 2'b00});
        send(8'h02, 8'h02, 3'd2, {16'h0002, 3'd2, 2'b00});
        send(8'h03, 8'h03, 3'd3, {16'h0000, 3'd3, 2'b00});
        n_checks++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got start=%b, required 1", start);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({start, rsp_valid, cmd_ready, A} !== {3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got start=%b rsp_valid=%b cmd_ready=%b A=%h, required 0 0 0 00",
                     start, rsp_valid, cmd_ready, A);
        end
        sb.delete();
        r0 = n_rsp;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        alu_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (n_rsp - r0 !== 0 || {rsp_valid, start} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_discard: got %0d responses rsp_valid=%b start=%b, required 0 0 0",
                     n_rsp - r0, rsp_valid, start);
        end
        send(8'h40, 8'h02, 3'd1, {16'h0042, 3'd1, 2'b00});
        wait_drain(ok);
        n_checks++;
        if (!ok || n_rsp - r0 !== 1) begin
            n_fail++;
            $display("FAIL rst_mid_new_add: got %0d responses, required 1", n_rsp - r0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fill();
        test_noop_illegal();
        test_timeout();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
